fetch_stage_unit: RTL and testbench

Fetch (F) stage of the pipelined core. Owns the fetch PC, issues requests to instruction memory over a valid/ready handshake with variable latency, and buffers returned instructions in a 2-entry queue. Drives the F/R instruction register (IR) consumed by register read and the hazard unit. Obeys StallPC/StallIR from the hazard unit and redirects from the C stage.

---
 rtl/fetch_stage_unit_pkg.sv | 17 +
 rtl/fetch_stage_unit_fifo.sv | 65 ++++++
 rtl/fetch_stage_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_stage_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_unit_pkg.sv
// -----------------------------------------------------------------------------
// HighLevelControl: types and constants shared by the fetch stage and by the
// downstream register-read / commit flush logic.
//   fetchState : state of the instruction-memory request tracker.
//   NOP_INSTR  : encoding of a pipeline bubble (addi x0,x0,0).
// -----------------------------------------------------------------------------
package HighLevelControl;

  typedef enum logic [1:0] {
    Fetch_IDLE    = 2'd0,  // no request outstanding
    Fetch_WAIT    = 2'd1,  // one request outstanding, response wanted
    Fetch_DISCARD = 2'd2   // one request outstanding, response is stale
  } fetchState;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_buffer_fifo: 2-entry synchronous FIFO holding fetched {instr, pc}.
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO).
//   i_flush      : empty the FIFO; same-cycle enqueue is dropped.
//   i_enq        : push i_enq_data this cycle.
//   i_deq        : pop the head this cycle.
//   o_occ        : number of stored entries (0..2).
//   o_head       : head entry; when empty, the incoming i_enq_data (bypass).
// A dequeue while empty and enqueueing consumes the incoming word directly
// (bypass) so it is never stored.
// -----------------------------------------------------------------------------
module fetch_buffer_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_enq,
  input  logic [W-1:0] i_enq_data,
  input  logic         i_deq,
  output logic [1:0]   o_occ,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_occ;

  logic         w_bypass;
  logic         w_write;
  logic         w_read;

  assign w_bypass = (r_occ == 2'd0) & i_enq & i_deq;
  assign w_write  = i_enq & ~w_bypass;
  assign w_read   = i_deq & (r_occ != 2'd0);

  assign o_occ  = r_occ;
  assign o_head = (r_occ == 2'd0) ? i_enq_data : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_write) r_wr_ptr <= ~r_wr_ptr;
      if (w_read)  r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_write} - {1'b0, w_read};
    end
  end

  // Storage needs no reset: occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (!reset && !i_flush && w_write) r_mem[r_wr_ptr] <= i_enq_data;
  end

  // The issuer only requests when the buffer can absorb the response.
  always_ff @(posedge clk) begin
    if (!reset && !i_flush) begin
      assert (!(w_write && !w_read && (r_occ == 2'd2)));
    end
  end

endmodule

// File: rtl/fetch_stage_unit.sv
// -----------------------------------------------------------------------------
// fetch_stage_unit: F stage of the pipelined core.
// Owns PC_F, issues instruction-memory requests, buffers responses in a
// 2-entry FIFO and drives the F/R instruction register.
//   clk, reset        : core clock, synchronous active-high reset.
//   StallPC, StallIR  : hazard unit: block issue / hold IR.
//   PCUpdate_C        : redirect from C; PCTarget_C is the new PC.
//   ImemReq_F/ImemAdr_F/ImemReady            : request channel.
//   ImemRspValid/ImemRspData                 : response channel.
//   Instr_R, PC_R, PCPlus4_R, InstrValid_R   : IR contents (valid=0 is bubble).
//   DbgState_F        : request tracker state (HighLevelControl::fetchState).
//
// Handshake: a request is accepted in a cycle where ImemReq_F and ImemReady are
// both high; ImemReq_F/ImemAdr_F stay meaningful only in that cycle. At most
// one request is outstanding and its response (ImemRspValid, one cycle wide)
// arrives one or more cycles after acceptance, in order.
// -----------------------------------------------------------------------------
module fetch_stage_unit
  import HighLevelControl::*;
#(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = HighLevelControl::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallPC,
  input  logic            StallIR,
  input  logic            PCUpdate_C,
  input  logic [XLEN-1:0] PCTarget_C,
  output logic            ImemReq_F,
  output logic [XLEN-1:0] ImemAdr_F,
  input  logic            ImemReady,
  input  logic            ImemRspValid,
  input  logic [31:0]     ImemRspData,
  output logic [31:0]     Instr_R,
  output logic [XLEN-1:0] PC_R,
  output logic [XLEN-1:0] PCPlus4_R,
  output logic            InstrValid_R,
  output logic [1:0]      DbgState_F
);

  fetchState         r_state;
  fetchState         w_state_next;
  logic [XLEN-1:0]   r_pc_f;
  logic [XLEN-1:0]   r_req_pc;     // address of the outstanding request
  logic [31:0]       r_instr_r;
  logic [XLEN-1:0]   r_pc_r;
  logic [XLEN-1:0]   r_pcplus4_r;
  logic              r_valid_r;

  logic              w_rsp_live;
  logic              w_enq;
  logic              w_deq;
  logic              w_req;
  logic              w_accept;
  logic [1:0]        w_occ;
  logic [1:0]        w_occ_next;
  logic [XLEN+31:0]  w_head;       // {instr, pc}

  // Only a response to a wanted request counts; IDLE/DISCARD responses die here.
  assign w_rsp_live = ImemRspValid & (r_state == Fetch_WAIT);
  assign w_enq      = w_rsp_live & ~PCUpdate_C;
  assign w_deq      = ~PCUpdate_C & ~StallIR & ((w_occ != 2'd0) | w_enq);
  assign w_occ_next = w_occ + {1'b0, w_enq} - {1'b0, w_deq};

  // Issue may ride on the same-cycle response (back-to-back with 1-cycle
  // memory), hence the combinational ImemRspValid -> ImemReq_F path.
  assign w_req    = ~reset & ~StallPC & ~PCUpdate_C
                  & ((r_state == Fetch_IDLE) | w_rsp_live)
                  & (w_occ_next <= 2'd1);
  assign w_accept = w_req & ImemReady;

  assign ImemReq_F    = w_req;
  assign ImemAdr_F    = r_pc_f;
  assign Instr_R      = r_instr_r;
  assign PC_R         = r_pc_r;
  assign PCPlus4_R    = r_pcplus4_r;
  assign InstrValid_R = r_valid_r;
  assign DbgState_F   = r_state;

  fetch_buffer_fifo #(.W(XLEN + 32)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (PCUpdate_C),
    .i_enq      (w_enq),
    .i_enq_data ({ImemRspData, r_req_pc}),
    .i_deq      (w_deq),
    .o_occ      (w_occ),
    .o_head     (w_head)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      Fetch_IDLE: begin
        if (w_accept) w_state_next = Fetch_WAIT;
      end
      Fetch_WAIT: begin
        // A redirect together with the response leaves nothing in flight.
        if (ImemRspValid)    w_state_next = w_accept ? Fetch_WAIT : Fetch_IDLE;
        else if (PCUpdate_C) w_state_next = Fetch_DISCARD;
      end
      Fetch_DISCARD: begin
        if (ImemRspValid) w_state_next = Fetch_IDLE;
      end
      default: w_state_next = Fetch_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= Fetch_IDLE;
      r_pc_f      <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_instr_r   <= NOP_INSTR;
      r_pc_r      <= '0;
      r_pcplus4_r <= XLEN'(4);
      r_valid_r   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (PCUpdate_C)    r_pc_f <= PCTarget_C;
      else if (w_accept) r_pc_f <= r_pc_f + XLEN'(4);

      if (w_accept) r_req_pc <= r_pc_f;

      // IR: redirect > StallIR > dequeue > bubble. Bubbles keep PC_R/PCPlus4_R.
      if (PCUpdate_C) begin
        r_instr_r <= NOP_INSTR;
        r_valid_r <= 1'b0;
      end else if (!StallIR) begin
        if (w_deq) begin
          r_instr_r   <= w_head[XLEN+31:XLEN];
          r_pc_r      <= w_head[XLEN-1:0];
          r_pcplus4_r <= w_head[XLEN-1:0] + XLEN'(4);
          r_valid_r   <= 1'b1;
        end else begin
          r_instr_r <= NOP_INSTR;
          r_valid_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage_unit: directed bench for fetch_stage_unit. A behavioural
// instruction memory with programmable latency answers every accepted request
// with mem_word(addr); IR contents are checked at negative edges against
// hand-traced cycle expectations, and the accepted-address log is compared
// against an expected queue at the end.
// -----------------------------------------------------------------------------
module tb_fetch_stage_unit;
  import HighLevelControl::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallPC;
  logic        StallIR;
  logic        PCUpdate_C;
  logic [31:0] PCTarget_C;
  logic        ImemReq_F;
  logic [31:0] ImemAdr_F;
  logic        ImemReady;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData  = '0;
  logic [31:0] Instr_R;
  logic [31:0] PC_R;
  logic [31:0] PCPlus4_R;
  logic        InstrValid_R;
  logic [1:0]  DbgState_F;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_stage_unit dut (
    .clk          (clk),
    .reset        (reset),
    .StallPC      (StallPC),
    .StallIR      (StallIR),
    .PCUpdate_C   (PCUpdate_C),
    .PCTarget_C   (PCTarget_C),
    .ImemReq_F    (ImemReq_F),
    .ImemAdr_F    (ImemAdr_F),
    .ImemReady    (ImemReady),
    .ImemRspValid (ImemRspValid),
    .ImemRspData  (ImemRspData),
    .Instr_R      (Instr_R),
    .PC_R         (PC_R),
    .PCPlus4_R    (PCPlus4_R),
    .InstrValid_R (InstrValid_R),
    .DbgState_F   (DbgState_F)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // ---------------- memory model ----------------
  int          lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_adr = '0;
  logic [31:0] acc_q[$];

  always @(posedge clk) begin
    if (ImemReq_F && ImemReady) begin
      mem_pend = 1'b1;
      mem_cnt  = lat;
      mem_adr  = ImemAdr_F;
      acc_q.push_back(ImemAdr_F);
    end
    #1;
    ImemRspValid = 1'b0;
    if (mem_pend) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        ImemRspValid = 1'b1;
        ImemRspData  = mem_word(mem_adr);
        mem_pend     = 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_ir(input string tag, input logic [31:0] pc);
    check_eq({tag, "_instr"}, Instr_R, mem_word(pc));
    check_eq({tag, "_pc"}, PC_R, pc);
    check_eq({tag, "_pc4"}, PCPlus4_R, pc + 32'd4);
    check_eq({tag, "_valid"}, 32'(InstrValid_R), 32'd1);
  endtask

  task automatic expect_bub(input string tag, input logic [31:0] hold_pc);
    check_eq({tag, "_instr"}, Instr_R, NOP);
    check_eq({tag, "_pc"}, PC_R, hold_pc);
    check_eq({tag, "_valid"}, 32'(InstrValid_R), 32'd0);
  endtask

  task automatic expect_reset(input string tag);
    check_eq({tag, "_instr"}, Instr_R, NOP);
    check_eq({tag, "_pc"}, PC_R, 32'h0);
    check_eq({tag, "_pc4"}, PCPlus4_R, 32'h4);
    check_eq({tag, "_valid"}, 32'(InstrValid_R), 32'd0);
    check_eq({tag, "_req"}, 32'(ImemReq_F), 32'd0);
    check_eq({tag, "_state"}, 32'(DbgState_F), 32'(Fetch_IDLE));
  endtask

  task automatic nstep();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_adr;

  initial begin
    reset = 1'b1; StallPC = 1'b0; StallIR = 1'b0;
    PCUpdate_C = 1'b0; PCTarget_C = '0; ImemReady = 1'b1;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
              32'h20, 32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208,
              32'h20C, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    repeat (3) nstep();
    expect_reset("rst");
    reset = 1'b0;

    // 1: streaming with 1-cycle memory
    nstep(); expect_bub("t1_first", 32'h0);
    nstep(); expect_ir("t1_w0", 32'h0);
    nstep(); expect_ir("t1_w1", 32'h4);
    nstep(); expect_ir("t1_w2", 32'h8);
    check_eq("t1_acc", 32'(acc_q.size()), 32'd4);

    // 2: stall IR and PC for three cycles
    StallIR = 1'b1; StallPC = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nstep(); expect_ir("t2_hold", 32'h8);
    end
    check_eq("t2_no_issue", 32'(acc_q.size()), 32'd4);
    StallIR = 1'b0; StallPC = 1'b0;
    nstep(); expect_ir("t2_rel0", 32'hC);
    nstep(); expect_ir("t2_rel1", 32'h10);

    // 3: 3-cycle memory latency
    lat = 3;
    nstep(); expect_ir("t3_a", 32'h14);
    nstep(); expect_bub("t3_b0", 32'h14);
    nstep(); expect_bub("t3_b1", 32'h14);
    nstep(); expect_ir("t3_c", 32'h18);
    nstep(); expect_bub("t3_b2", 32'h18);
    nstep(); expect_bub("t3_b3", 32'h18);
    nstep(); expect_ir("t3_d", 32'h1C);

    // 4: redirect while 0x20 is outstanding
    check_eq("t4_wait", 32'(DbgState_F), 32'(Fetch_WAIT));
    PCUpdate_C = 1'b1; PCTarget_C = 32'h100;
    nstep(); expect_bub("t4_redir", 32'h1C);
    check_eq("t4_discard", 32'(DbgState_F), 32'(Fetch_DISCARD));
    PCUpdate_C = 1'b0; lat = 1;
    for (int k = 0; k < 3; k++) begin
      nstep(); expect_bub("t4_gap", 32'h1C);
    end
    nstep(); expect_ir("t4_tgt", 32'h100);

    // 5: redirect with StallIR while the queue holds two
    StallIR = 1'b1;
    nstep(); expect_ir("t5_hold0", 32'h100);
    nstep(); expect_ir("t5_hold1", 32'h100);
    PCUpdate_C = 1'b1; PCTarget_C = 32'h200;
    nstep(); expect_bub("t5_flush", 32'h100);
    PCUpdate_C = 1'b0; StallIR = 1'b0;
    nstep(); expect_bub("t5_gap", 32'h100);
    nstep(); expect_ir("t5_tgt", 32'h200);
    nstep(); expect_ir("t5_tgt4", 32'h204);

    // 6: reset while a request is outstanding
    lat = 3;
    nstep(); expect_ir("t6_pre", 32'h208);
    check_eq("t6_wait", 32'(DbgState_F), 32'(Fetch_WAIT));
    reset = 1'b1;
    nstep(); expect_reset("t6_rst0");
    lat = 1;
    nstep();
    nstep(); expect_reset("t6_rst2");
    reset = 1'b0;
    nstep(); expect_bub("t6_first", 32'h0);
    nstep(); expect_ir("t6_w0", 32'h0);
    nstep(); expect_ir("t6_w1", 32'h4);

    // memory back-pressure: ImemReady low for two cycles
    ImemReady = 1'b0;
    nstep(); expect_ir("rdy_w2", 32'h8);
    nstep(); expect_bub("rdy_b0", 32'h8);
    ImemReady = 1'b1;
    nstep(); expect_bub("rdy_b1", 32'h8);
    nstep(); expect_ir("rdy_w3", 32'hC);

    // accepted-address scoreboard
    check_eq("acc_count", 32'(acc_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got_adr = (i < acc_q.size()) ? acc_q[i] : 32'hFFFF_FFFF;
      check_eq($sformatf("acc_adr[%0d]", i), got_adr, exp_q[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
